// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a selectable first-word-fall-through read mode.
//
// Handshake: a write is taken on any edge where wr_en=1 and full=0; a read
// is taken on any edge where rd_en=1 and empty=0. Requests made against
// the opposite flag are dropped and only raise the matching error flag.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [LW-1:0]    level_next;

    // Acceptance uses the registered flags, so a read never frees space for
    // a same-cycle write at full, nor a write feed a same-cycle read at empty.
    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        level_next = level + LW'(wr_acc) - LW'(rd_acc);
    end

    // Storage array; deliberately not reset, writes are dropped during reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and status flags, all derived from level_next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level        <= level_next;
            full         <= (level_next == LW'(DEPTH));
            empty        <= (level_next == '0);
            almost_full  <= (level_next >= LW'(AF_LEVEL));
            almost_empty <= (level_next <= LW'(AE_LEVEL));
        end
    end

    // Sticky error flags; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; valid whenever empty=0.
            always_comb begin
                dout = mem[rd_ptr];
            end
        end else begin : g_std
            // Registered read port: dout updates one edge after rd_acc.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout <= '0;
                end else if (rd_acc) begin
                    dout <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a standard-mode and an FWFT-mode FIFO with the
// same stimulus and compares both against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 2;
    localparam int AE = 1;
    localparam int LW = $clog2(D) + 1;

    // clock/reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         wr_en;
    logic [W-1:0] din;
    logic         rd_en;
    logic         err_clr;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_of, s_uf;
    logic          f_full, f_empty, f_af, f_ae, f_of, f_uf;
    logic [LW-1:0] s_level, f_level;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .err_clr(err_clr), .dout(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
        .overflow(s_of), .underflow(s_uf)
    );

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .err_clr(err_clr), .dout(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
        .overflow(f_of), .underflow(f_uf)
    );

    // scoreboard: expected contents and expected sticky/registered outputs
    logic [W-1:0] exp_q[$];
    logic         m_of;
    logic         m_uf;
    logic [W-1:0] m_dout;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one clock edge of FIFO behaviour on the queue.
    task automatic model_edge();
        int  n;
        bit  was_full;
        bit  was_empty;
        n = exp_q.size();
        if (!rst_n) begin
            exp_q.delete();
            m_of   = 1'b0;
            m_uf   = 1'b0;
            m_dout = '0;
        end else begin
            was_full  = (n == D);
            was_empty = (n == 0);
            if (rd_en && !was_empty) m_dout = exp_q.pop_front();
            if (wr_en && !was_full) exp_q.push_back(din);
            if (wr_en && was_full) m_of = 1'b1;
            else if (err_clr) m_of = 1'b0;
            if (rd_en && was_empty) m_uf = 1'b1;
            else if (err_clr) m_uf = 1'b0;
        end
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        chk("std_level", 32'(s_level), 32'(n));
        chk("std_full", 32'(s_full), 32'(n == D));
        chk("std_empty", 32'(s_empty), 32'(n == 0));
        chk("std_afull", 32'(s_af), 32'(n >= AF));
        chk("std_aempty", 32'(s_ae), 32'(n <= AE));
        chk("std_overflow", 32'(s_of), 32'(m_of));
        chk("std_underflow", 32'(s_uf), 32'(m_uf));
        chk("std_dout", 32'(s_dout), 32'(m_dout));
        chk("fwft_level", 32'(f_level), 32'(n));
        chk("fwft_empty", 32'(f_empty), 32'(n == 0));
        chk("fwft_full", 32'(f_full), 32'(n == D));
        chk("fwft_flags", {f_af, f_ae, f_of, f_uf}, {n >= AF, n <= AE, m_of, m_uf});
        if (n != 0) chk("fwft_dout", 32'(f_dout), 32'(exp_q[0]));
    endtask

    // driver task: apply one cycle of inputs, advance, update model, check
    task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                        input logic c, input logic rs);
        wr_en   = w;
        din     = d;
        rd_en   = r;
        err_clr = c;
        rst_n   = rs;
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
        exp_q.delete(); m_of = 1'b0; m_uf = 1'b0; m_dout = '0;
        #1;
        // reset, with requests present that must be ignored
        step(1, 8'h99, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // fill to full, then overflow
        step(1, 8'h11, 0, 0, 1);
        step(1, 8'h22, 0, 0, 1);
        step(1, 8'h33, 0, 0, 1);
        step(1, 8'h44, 0, 0, 1);
        step(1, 8'h55, 0, 0, 1);
        step(0, 8'h00, 0, 1, 1);

        // drain, then underflow keeping last dout
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 1, 1);

        // pointer wrap with alternating write/read
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(i), 0, 0, 1);
            step(0, 8'h00, 1, 0, 1);
        end

        // simultaneous read and write at level 2
        step(1, 8'hA1, 0, 0, 1);
        step(1, 8'hA2, 0, 0, 1);
        step(1, 8'hA3, 1, 0, 1);
        step(1, 8'hA4, 1, 0, 1);
        // fill to full, then both at full
        step(1, 8'hA5, 0, 0, 1);
        step(1, 8'hA6, 0, 0, 1);
        step(1, 8'hA7, 1, 0, 1);
        // drain to empty, then both at empty
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 1);
        step(1, 8'hB0, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // FWFT visibility without rd_en, then pop
        step(1, 8'hA5, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // reset at level 3, old data must never reappear
        step(1, 8'hC1, 0, 1, 1);
        step(1, 8'hC2, 0, 0, 1);
        step(1, 8'hC3, 0, 0, 1);
        step(1, 8'hC4, 0, 0, 0);
        step(1, 8'hD1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // err_clr coincident with an overflow event
        for (int i = 0; i < 4; i++) step(1, 8'(8'hE0 + i), 0, 0, 1);
        step(1, 8'hEF, 0, 1, 1);
        step(0, 8'h00, 0, 1, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) >= 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO: the single-domain successor to our fixed 4x4 asynchronous FIFO. It is generalised in data width and depth, and adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It buffers between producer and consumer logic that share one clock, such as command queues and stream elastic buffers.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when level ≥ AF_LEVEL; 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when level ≤ AE_LEVEL; 0..DEPTH-1.
- FWFT, 0: 0 = standard read (registered dout), 1 = first-word-fall-through.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of the current head).
- err_clr  in  1  clears the overflow and underflow flags.
- dout  out  WIDTH  read data.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.
- level  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage is a DEPTH×WIDTH register array. The memory is not reset.
- wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_acc = wr_en & ~full. On wr_acc, mem[wr_ptr] <= din and wr_ptr increments.
- Read acceptance: rd_acc = rd_en & ~empty. On rd_acc, rd_ptr increments.
- full and empty are the registered flags. A read does not free space for a same-cycle write when full. A write does not supply a same-cycle read when empty.
- level_next = level + wr_acc − rd_acc. If both are accepted, level is unchanged and both pointers advance.
- full, empty, almost_full and almost_empty are registered and computed from level_next.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr].
  - Otherwise dout holds its value.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally and is valid whenever empty=0.
  - rd_en pops the head; the next word appears on dout after the edge.
  - dout is don't-care while empty=1.
- Error flags:
  - overflow sets on wr_en & full.
  - underflow sets on rd_en & empty.
  - Both clear on err_clr. If set and clear occur in the same cycle, set wins.
  - The rejected operation has no other effect: pointers, level and memory are unchanged.
- Reset (rst_n=0 at a clock edge), regardless of in-flight operations:
  - pointers = 0, level = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (or 1 if AF_LEVEL = 0, which is disallowed), overflow = 0, underflow = 0.
  - dout = 0 in standard mode.
  - wr_en and rd_en are ignored during reset.

## Timing
- Write-to-read latency: a word written at edge N deasserts empty after edge N. In standard mode it can be read with rd_en at edge N+1 and appears on dout after N+1. In FWFT mode it is visible on dout right after edge N.
- Standard-mode read latency: 1 cycle from rd_acc to dout.
- All flags and level update on the same edge as the accepting operation. There is no extra pipeline delay.
- Throughput: one write and one read per cycle, sustained.
- The reset release takes effect at the first rising edge with rst_n=1.

## Test plan
- Reset, then write DEPTH words: DEPTH=4, WIDTH=8, write 0x11, 0x22, 0x33, 0x44.
  - Required: level 1→4, almost_full asserts at level 2 (AF_LEVEL=2), full=1 after the 4th edge.
  - A 5th write of 0x55 sets overflow and leaves level=4.
- Drain in standard mode: dout reads 0x11, 0x22, 0x33, 0x44, each one cycle after its rd_en.
  - Required: empty=1 after the 4th read. An extra rd_en sets underflow and leaves dout=0x44.
- Pointer wrap: 10 alternating single write/read pairs with data i.
  - Required: each read returns i, level toggles 0/1, and neither error flag sets.
- Simultaneous read and write:
  - At level=2: level stays 2 and data order is preserved.
  - At full with rd_en & wr_en: write is rejected, overflow=1, level=3.
  - At empty with both: read is rejected, underflow=1, level=1.
- FWFT=1: write 0xA5 into an empty FIFO.
  - Required: dout=0xA5 and empty=0 on the next cycle without rd_en. rd_en pops it and empty=1.
- Reset and error clear:
  - Assert rst_n=0 for one cycle at level=3: level=0, empty=1, overflow=0. Old data is never returned.
  - err_clr with a simultaneous overflow event: overflow remains 1.
